// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
//   Shared definitions for the reset sequencer:
//     - seq_state_e   : sequencer FSM states, 2-bit binary encoding
//     - cnt_width()   : width of the shared stretch/step counter
//     - params_legal(): parameter legality check used at elaboration
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  // One counter serves both the stretch and the step phases, so it is sized
  // for the longer of the two; a single-cycle phase still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned stretch,
                                            input int unsigned step);
    int unsigned longest;
    longest = (stretch > step) ? stretch : step;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

  function automatic bit params_legal(input int unsigned sync_stages,
                                      input int unsigned stretch,
                                      input int unsigned step,
                                      input int unsigned num_outs);
    return (sync_stages >= 2) && (stretch >= 1) && (step >= 1) &&
           (num_outs >= 1) && (num_outs <= 16);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
//   Reset-release synchronizer: a SYNC_STAGES-deep chain of flops whose first
//   D input is tied high. All stages clear asynchronously while reset is low;
//   the 1 walks through the chain after release.
//   Ports:
//     clk    in  clock
//     reset  in  raw reset, asynchronous, active-low
//     sync_q out synchronized release (1 = reset released)
// -----------------------------------------------------------------------------
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Turns one raw board reset into NUM_OUTS active-low resets that assert
//   asynchronously, release synchronously, are stretched after release and
//   then deassert one at a time (bit 0 first). A level soft_req sampled while
//   fully released re-runs the stretch/step sequence and answers with a
//   one-cycle soft_ack when it completes.
//   Ports:
//     clk          in  clock
//     reset        in  raw reset, asynchronous, active-low
//     soft_req     in  software reset request (level, held until soft_ack)
//     rst_n_out    out generated resets, active-low, registered
//     all_released out high while every rst_n_out bit is 1
//     soft_ack     out one-cycle pulse when a soft sequence completes
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STEP_CYCLES    = 8,
  parameter int unsigned NUM_OUTS       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                all_released,
  output logic                soft_ack
);

  if (!params_legal(SYNC_STAGES, STRETCH_CYCLES, STEP_CYCLES, NUM_OUTS)) begin : g_bad_params
    $error("reset_sequencer: illegal parameter combination");
  end

  localparam int unsigned CW = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
  localparam int unsigned IW = (NUM_OUTS <= 1) ? 1 : $clog2(NUM_OUTS);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OUTS - 1);

  logic                sync_q;
  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [NUM_OUTS-1:0] rst_q, rst_d;
  logic                ack_q, ack_d;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk   (clk),
    .reset (reset),
    .sync_q(sync_q)
  );

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    rst_d     = rst_q;
    ack_d     = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        if (sync_q) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end
      end

      ST_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          rst_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IW'(1);
          if (NUM_OUTS == 1) begin
            state_d   = ST_RUN;
            ack_d     = pending_q;
            pending_d = 1'b0;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          rst_d[idx_q] = 1'b1;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d   = ST_RUN;
            ack_d     = pending_q;
            pending_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // Only place soft_req is looked at; outside RUN it is simply ignored.
        if (soft_req) begin
          rst_d     = '0;
          cnt_d     = '0;
          pending_d = 1'b1;
          state_d   = ST_STRETCH;
        end
      end

      default: state_d = ST_ASSERT;
    endcase
  end

  // The output resets are ordinary control flops: they must clear the instant
  // the raw reset falls, so they share the async clear with the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      rst_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      rst_q     <= rst_d;
      ack_q     <= ack_d;
    end
  end

  assign rst_n_out    = rst_q;
  assign all_released = &rst_q;
  assign soft_ack     = ack_q;

endmodule
